ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin arbiter sharing one single-ported-per-direction synchronous RAM between an instruction-fetch requester (port 0) and a load/store requester (port 1). Accepts at most one request per cycle, drives the RAM read/write address, write strobe and write data, and routes the RAM's 1-cycle-latency read data back to the requester that issued the read. It sits between the CPU front-end/datapath and the RAM instance.

## Interface
- dataWidth, 16, RAM word width
- addrWidth, 8, RAM address width
- maxLock, 4, max consecutive grants to one port while locked (≥1)

- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request valid; held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  addrWidth  request address
- wdata0 / wdata1  in  dataWidth  write data
- lock0 / lock1  in  1  keep grant on consecutive requests (macro-gated)
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid this cycle
- rdata  out  dataWidth  read data, shared bus, qualified by rvalid0/1
- ramReadAddress  out  addrWidth  to RAM read address
- ramWriteAddress  out  addrWidth  to RAM write address
- ramWrite  out  1  to RAM write enable
- ramIn  out  dataWidth  to RAM write data
- ramOut  in  dataWidth  from RAM registered read data

## Operation
- Per cycle, pick at most one of req0/req1; assert exactly that gnt. Never both gnts.
- Round-robin: one-bit priority pointer `last`; on a grant, `last` := granted port. If both request, grant port ≠ last. Single requester always granted (no idle cycles).
- Granted write: ramWrite=1, ramWriteAddress=addr, ramIn=wdata. No rvalid issued.
- Granted read: ramRead Address=addr, ramWrite=0; register pending tag {valid, port}.
- No grant: ramWrite=0, both addresses and ramIn driven 0.
- rdata = ramOut unconditionally; rvalidN = pending valid && pending port == N.
- Write then read of same address on consecutive cycles returns new data (RAM write lands at edge before read).

## Timing
- Grant latency 0: gnt combinational from req in same cycle.
- Read latency 1: read granted in cycle N → rvalid in N+1 with ramOut. Back-to-back reads give rvalid every cycle.
- Reset (resetn=0, async): gnt0/gnt1=0, ramWrite=0, rvalid0/1=0, pending cleared, last=1 (port 0 wins first contention), lock state IDLE, lock count 0. Read granted in the cycle reset asserts never produces rvalid.
- ramWrite gated by resetn combinationally: no RAM write while in reset.
- req dropped without gnt: legal, no side effect.

## Configuration
- Macro RAM_ARB_LOCK_EN.
- Defined: FSM IDLE/LOCKED. In IDLE a grant with lockN=1 → LOCKED(owner=N), count=1. In LOCKED only owner may be granted; each owner grant increments count. Leave to IDLE when owner grant has lock=0, owner reqN=0 in a cycle, or count reaches maxLock (that grant is last; next cycle normal round-robin with last=owner). Other port stalls while LOCKED.
- Undefined: lock0/lock1 ignored, no FSM, pure round-robin.

## Structure
- Package ram_arb_pkg: port index typedef (1 bit), lock FSM state enum {IDLE, LOCKED}, lock counter width constant $clog2(maxLock+1).
- One sub-module ram_arb_rr: 2-way round-robin picker (req[1:0], last, mask → gnt[1:0]); top holds pointer, pending tag, lock FSM, RAM muxing.

## Test plan
- Reset: resetn=0 with req0=req1=1 → gnt=00, ramWrite=0, rvalid=00; release → first contention grants port 0.
- Contention: req0=req1=1 reads addr0=0x10, addr1=0x20 for 4 cycles → gnt alternates 0,1,0,1; rvalid alternates next cycle with mem[0x10], mem[0x20].
- Write-read: port 1 writes 0xBEEF to 0x05, next cycle port 0 reads 0x05 → rvalid0 with rdata=0xBEEF one cycle later.
- Single requester: req1 only, 3 reads → gnt1 every cycle, rvalid1 three consecutive cycles.
- Lock (RAM_ARB_LOCK_EN, maxLock=4): req0+lock0 held, req1 held → gnt0 four cycles, then gnt1; without macro → alternation.
- Reset mid-read: read granted in cycle N, resetn=0 in N → no rvalid in N+1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types for the two-port RAM arbiter: port index, lock FSM
//            state encoding and the lock-counter width helper.
// Ports    : none (package)
// Macro    : RAM_ARB_LOCK_EN (consumers only; the package is unconditional)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Index of a requester: 0 = instruction fetch, 1 = load/store.
    typedef logic port_t;

    // Grant-lock state machine encoding.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Width of a counter that must hold values 0..max_lock inclusive.
    function automatic int lock_cnt_width(input int max_lock);
        return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
    endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rr
// Purpose  : Two-way round-robin picker. Masked-out requests are ignored; on
//            contention the port that was NOT granted last wins.
// Ports    : i_req[1:0]  raw requests
//            i_last      port granted most recently
//            i_mask[1:0] ports eligible this cycle
//            o_gnt[1:0]  one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);

    logic [1:0] w_req;

    assign w_req = i_req & i_mask;

    always_comb begin
        o_gnt = w_req;
        if (w_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule : ram_arb_rr
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one synchronous RAM (1-cycle registered read) between an
//            instruction-fetch port (0) and a load/store port (1). At most one
//            request is granted per cycle; read data is routed back to the
//            issuing port one cycle later via rvalid0/rvalid1.
// Ports    : clk, resetn (async, active low)
//            req/we/addr/wdata/lock 0,1   requester side
//            gnt0/gnt1 (combinational), rvalid0/rvalid1, rdata
//            ramReadAddress, ramWriteAddress, ramWrite, ramIn, ramOut
// Macro    : RAM_ARB_LOCK_EN - enables the grant-lock FSM (lock0/lock1).
//            Undefined: lock inputs are ignored, pure round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int dataWidth = 16,
    parameter int addrWidth = 8,
    parameter int maxLock   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [addrWidth-1:0] addr0,
    input  logic [addrWidth-1:0] addr1,
    input  logic [dataWidth-1:0] wdata0,
    input  logic [dataWidth-1:0] wdata1,
    input  logic                 lock0,
    input  logic                 lock1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [dataWidth-1:0] rdata,
    output logic [addrWidth-1:0] ramReadAddress,
    output logic [addrWidth-1:0] ramWriteAddress,
    output logic                 ramWrite,
    output logic [dataWidth-1:0] ramIn,
    input  logic [dataWidth-1:0] ramOut
);

    logic [1:0]           w_req;
    logic [1:0]           w_mask;
    logic [1:0]           w_gnt;
    logic                 w_any;
    port_t                w_sel;
    logic                 w_we;
    logic [addrWidth-1:0] w_addr;
    logic [dataWidth-1:0] w_wdata;

    logic                 r_last;
    logic                 r_pend_valid;
    port_t                r_pend_port;

    // Requests are suppressed while in reset so no grant (and therefore no
    // RAM write or pending read) can be produced during reset.
    assign w_req = {req1, req0} & {2{resetn}};

    ram_arb_rr u_rr (
        .i_req  (w_req),
        .i_last (r_last),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    assign gnt0 = w_gnt[0];
    assign gnt1 = w_gnt[1];

    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[1];
    assign w_we    = w_sel ? we1    : we0;
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;

    // RAM side: everything is forced to zero when nothing is granted.
    assign ramWrite        = w_any & w_we & resetn;
    assign ramWriteAddress = ramWrite ? w_addr  : '0;
    assign ramIn           = ramWrite ? w_wdata : '0;
    assign ramReadAddress  = (w_any & ~w_we) ? w_addr : '0;

    // Read data is a shared bus; rvalidN says whose it is.
    assign rdata   = ramOut;
    assign rvalid0 = r_pend_valid & (r_pend_port == 1'b0);
    assign rvalid1 = r_pend_valid & (r_pend_port == 1'b1);

    // Priority pointer and pending-read tag. last resets to 1 so port 0 wins
    // the first contention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last       <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_port  <= 1'b0;
        end else begin
            if (w_any) begin
                r_last <= w_sel;
            end
            r_pend_valid <= w_any & ~w_we;
            r_pend_port  <= w_sel;
        end
    end

`ifdef RAM_ARB_LOCK_EN
    localparam int c_CNT_W = lock_cnt_width(maxLock);

    lock_state_t        r_state;
    port_t              r_owner;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_lock_sel;

    assign w_lock_sel = w_sel ? lock1 : lock0;

    // While locked only the owner is eligible; the other port stalls.
    assign w_mask = (r_state == LOCKED) ? (r_owner ? 2'b10 : 2'b01) : 2'b11;

    // r_cnt counts owner grants including the one that entered LOCKED; the
    // grant that brings it to maxLock is the last one of the burst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // With maxLock == 1 the entering grant is already the last.
                    if (w_any && w_lock_sel && (maxLock > 1)) begin
                        r_state <= LOCKED;
                        r_owner <= w_sel;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // No grant here means the owner dropped its request.
                    if (!w_any || !w_lock_sel ||
                        (r_cnt == c_CNT_W'(maxLock - 1))) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
`else
    logic w_unused_lock;

    assign w_mask        = 2'b11;
    assign w_unused_lock = lock0 ^ lock1;
`endif

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. A behavioural RAM with a
//            registered read port is attached. Grants and RAM-side outputs
//            are checked as each directed vector is applied; expected read
//            responses are queued and matched by an independent monitor.
// Macro    : RAM_ARB_LOCK_EN selects the expected grant pattern of the lock
//            scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [7:0]  ramReadAddress, ramWriteAddress;
    logic        ramWrite;
    logic [15:0] ramIn;
    logic [15:0] ramOut;

    logic [15:0] mem [0:255];
    exp_t        q[$];
    int          checks;
    int          errors;

    ram_arbiter #(
        .dataWidth (16),
        .addrWidth (8),
        .maxLock   (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req0            (req0),
        .req1            (req1),
        .we0             (we0),
        .we1             (we1),
        .addr0           (addr0),
        .addr1           (addr1),
        .wdata0          (wdata0),
        .wdata1          (wdata1),
        .lock0           (lock0),
        .lock1           (lock1),
        .gnt0            (gnt0),
        .gnt1            (gnt1),
        .rvalid0         (rvalid0),
        .rvalid1         (rvalid1),
        .rdata           (rdata),
        .ramReadAddress  (ramReadAddress),
        .ramWriteAddress (ramWriteAddress),
        .ramWrite        (ramWrite),
        .ramIn           (ramIn),
        .ramOut          (ramOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write lands at the edge, read data registered.
    always @(posedge clk) begin
        if (ramWrite) mem[ramWriteAddress] <= ramIn;
        ramOut <= mem[ramReadAddress];
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            exp_t e;
            checks++;
            if (rvalid0 && rvalid1) begin
                errors++;
                $display("FAIL rvalid_both t=%0t actual=11 required=one-hot", $time);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected t=%0t actual rvalid=%b%b required none",
                         $time, rvalid1, rvalid0);
            end else begin
                e = q.pop_front();
                if (rvalid1 !== e.port || rdata !== e.data) begin
                    errors++;
                    $display("FAIL rdata t=%0t actual port=%0d data=%h required port=%0d data=%h",
                             $time, rvalid1, rdata, e.port, e.data);
                end
            end
        end
    end

    // Apply one vector just after a rising edge, check at the falling edge.
    task automatic step(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic l0, input logic l1,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] eg, input logic [15:0] ed);
        logic ew;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
        ew = (eg[0] & w0) | (eg[1] & w1);
        checks++;
        if ({gnt1, gnt0} !== eg) begin
            errors++;
            $display("FAIL gnt t=%0t actual=%b required=%b", $time, {gnt1, gnt0}, eg);
        end
        checks++;
        if (ramWrite !== ew) begin
            errors++;
            $display("FAIL ramWrite t=%0t actual=%b required=%b", $time, ramWrite, ew);
        end
        if (eg == 2'b00) begin
            checks++;
            if (ramReadAddress !== 8'h00 || ramWriteAddress !== 8'h00 || ramIn !== 16'h0000) begin
                errors++;
                $display("FAIL idle_bus t=%0t actual ra=%h wa=%h in=%h required 0",
                         $time, ramReadAddress, ramWriteAddress, ramIn);
            end
        end else if (ew) begin
            checks++;
            if (ramWriteAddress !== (eg[1] ? a1 : a0) || ramIn !== (eg[1] ? d1 : d0)) begin
                errors++;
                $display("FAIL write_bus t=%0t actual wa=%h in=%h required wa=%h in=%h", $time,
                         ramWriteAddress, ramIn, eg[1] ? a1 : a0, eg[1] ? d1 : d0);
            end
        end else begin
            checks++;
            if (ramReadAddress !== (eg[1] ? a1 : a0)) begin
                errors++;
                $display("FAIL read_addr t=%0t actual=%h required=%h", $time,
                         ramReadAddress, eg[1] ? a1 : a0);
            end
            q.push_back('{port: eg[1], data: ed});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        resetn = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 8'h10; addr1 = 8'h20; wdata0 = '0; wdata1 = '0;

        // Reset with both requesting.
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt1, gnt0, ramWrite, rvalid1, rvalid0} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs actual gnt=%b wr=%b rv=%b required all 0",
                     {gnt1, gnt0}, ramWrite, {rvalid1, rvalid0});
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // Contention: alternation starting with port 0.
        step(1, 1, 0, 0, 0, 0, 8'h10, 8'h20, 16'h0, 16'h0, 2'b01, 16'hA010);
        step(1, 1, 0, 0, 0, 0, 8'h10, 8'h20, 16'h0, 16'h0, 2'b10, 16'hA020);
        step(1, 1, 0, 0, 0, 0, 8'h10, 8'h20, 16'h0, 16'h0, 2'b01, 16'hA010);
        step(1, 1, 0, 0, 0, 0, 8'h10, 8'h20, 16'h0, 16'h0, 2'b10, 16'hA020);
        idle();

        // Write then read the same address on consecutive cycles.
        step(0, 1, 0, 1, 0, 0, 8'h00, 8'h05, 16'h0, 16'hBEEF, 2'b10, 16'h0);
        step(1, 0, 0, 0, 0, 0, 8'h05, 8'h00, 16'h0, 16'h0, 2'b01, 16'hBEEF);
        idle();

        // Single requester on port 1: granted every cycle.
        step(0, 1, 0, 0, 0, 0, 8'h00, 8'h30, 16'h0, 16'h0, 2'b10, 16'hA030);
        step(0, 1, 0, 0, 0, 0, 8'h00, 8'h31, 16'h0, 16'h0, 2'b10, 16'hA031);
        step(0, 1, 0, 0, 0, 0, 8'h00, 8'h32, 16'h0, 16'h0, 2'b10, 16'hA032);
        idle();

        // Lock: port 0 holds lock while port 1 also requests.
`ifdef RAM_ARB_LOCK_EN
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b10, 16'hA041);
`else
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b10, 16'hA041);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b10, 16'hA041);
        step(1, 1, 0, 0, 1, 0, 8'h40, 8'h41, 16'h0, 16'h0, 2'b01, 16'hA040);
`endif
        idle();
        idle();

        // Reset asserted in the same cycle a read is granted: no rvalid.
        req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h50;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL midreset_gnt actual=%b required=01", {gnt1, gnt0});
        end
        #2;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({rvalid1, rvalid0, gnt1, gnt0} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_rvalid actual rv=%b gnt=%b required 00/00",
                     {rvalid1, rvalid0}, {gnt1, gnt0});
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // Normal operation resumes after reset.
        step(1, 0, 0, 0, 0, 0, 8'h60, 8'h00, 16'h0, 16'h0, 2'b01, 16'hA060);
        idle();
        idle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses actual=%0d required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
